// File: rtl/llc_repl_ctrl_if.sv
// Lookup request / replacement response channel between tag compare and the PLRU controller.
// The master issues lookups and consumes responses; the slave is the replacement controller.
interface llc_repl_ctrl_if #(
   parameter int N_WAY    = 16,
   parameter int NUM_SETS = 16384,
   parameter int SET_W    = $clog2(NUM_SETS),
   parameter int WAY_W    = $clog2(N_WAY)
);
   logic             req_valid;
   logic             req_ready;
   logic [SET_W-1:0] req_set;
   logic             req_hit;
   logic [WAY_W-1:0] req_way;
   logic [N_WAY-1:0] req_inv_mask;
   logic             resp_valid;
   logic             resp_ready;
   logic [WAY_W-1:0] resp_way;
   logic             resp_evict;

   modport master (
      output req_valid, req_set, req_hit, req_way, req_inv_mask, resp_ready,
      input  req_ready, resp_valid, resp_way, resp_evict
   );

   modport slave (
      input  req_valid, req_set, req_hit, req_way, req_inv_mask, resp_ready,
      output req_ready, resp_valid, resp_way, resp_evict
   );
endinterface

// File: rtl/llc_repl_ctrl.sv
// Tree pseudo-LRU replacement controller: one lookup per transaction, victim selection
// (invalid way first, else tree walk), MRU write-back, and a set-by-set clear sweep.
module llc_repl_ctrl #(
   parameter int N_WAY    = 16,
   parameter int NUM_SETS = 16384,
   parameter int SET_W    = $clog2(NUM_SETS),
   parameter int WAY_W    = $clog2(N_WAY)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear_req,
   output logic                busy,
   llc_repl_ctrl_if.slave      bus
);

   if (N_WAY < 2 || (N_WAY & (N_WAY - 1)) != 0) begin : g_bad_n_way
      $fatal(1, "llc_repl_ctrl: N_WAY must be a power of two >= 2");
   end
   if (NUM_SETS < 2 || (NUM_SETS & (NUM_SETS - 1)) != 0) begin : g_bad_num_sets
      $fatal(1, "llc_repl_ctrl: NUM_SETS must be a power of two >= 2");
   end

   localparam int NODES = N_WAY - 1;
   localparam logic [NODES-1:0] NODE_ONE = NODES'(1'b1);
   localparam logic [SET_W-1:0] LAST_SET = SET_W'(NUM_SETS - 1);

   typedef enum logic [2:0] {
      ST_CLEAR  = 3'd0,
      ST_IDLE   = 3'd1,
      ST_LOOKUP = 3'd2,
      ST_RESP   = 3'd3,
      ST_UPDATE = 3'd4
   } state_t;

   // Node value 1 = last access went to the upper half; the victim follows the opposite side.
   function automatic logic [WAY_W-1:0] plru_victim(input logic [NODES-1:0] tree);
      logic [WAY_W-1:0] way_v;
      logic [NODES-1:0] sh_v;
      logic             dir_v;
      int unsigned      node_v;
      way_v  = {WAY_W{1'b0}};
      node_v = 32'd0;
      for (int lvl = 0; lvl < WAY_W; lvl++) begin
         sh_v   = tree >> node_v;
         dir_v  = ~sh_v[0];
         way_v  = (way_v << 1) | WAY_W'(dir_v);
         node_v = 32'd2 * node_v + 32'd1 + {31'd0, dir_v};
      end
      return way_v;
   endfunction

   function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] tree,
                                                   input logic [WAY_W-1:0] way);
      logic [NODES-1:0] tree_v;
      logic [WAY_W-1:0] wsh_v;
      logic             dir_v;
      int unsigned      node_v;
      tree_v = tree;
      node_v = 32'd0;
      for (int lvl = WAY_W - 1; lvl >= 0; lvl--) begin
         wsh_v  = way >> lvl;
         dir_v  = wsh_v[0];
         tree_v = (tree_v & ~(NODE_ONE << node_v)) | (NODES'(dir_v) << node_v);
         node_v = 32'd2 * node_v + 32'd1 + {31'd0, dir_v};
      end
      return tree_v;
   endfunction

   function automatic logic [WAY_W-1:0] lowest_set(input logic [N_WAY-1:0] mask);
      logic [WAY_W-1:0] way_v;
      logic [N_WAY-1:0] sh_v;
      way_v = {WAY_W{1'b0}};
      for (int i = N_WAY - 1; i >= 0; i--) begin
         sh_v = mask >> i;
         if (sh_v[0]) begin
            way_v = WAY_W'(i);
         end
      end
      return way_v;
   endfunction

   logic [NODES-1:0] plru_mem [NUM_SETS];

   state_t           state_r, state_next_s;
   logic [SET_W-1:0] cnt_r;
   logic [SET_W-1:0] set_r;
   logic             hit_r;
   logic [WAY_W-1:0] way_r;
   logic [N_WAY-1:0] inv_r;
   logic [NODES-1:0] tree_r;
   logic             busy_r, req_ready_r, resp_valid_r, resp_evict_r;
   logic [WAY_W-1:0] resp_way_r;
   logic [NODES-1:0] rd_tree_s;
   logic [WAY_W-1:0] chosen_way_s;
   logic             chosen_evict_s;

   assign busy           = busy_r;
   assign bus.req_ready  = req_ready_r;
   assign bus.resp_valid = resp_valid_r;
   assign bus.resp_way   = resp_way_r;
   assign bus.resp_evict = resp_evict_r;

   // Next-state decode for the controller sequence.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_CLEAR: begin
            if (cnt_r == LAST_SET) state_next_s = ST_IDLE;
            else                   state_next_s = ST_CLEAR;
         end
         ST_IDLE: begin
            if (clear_req)          state_next_s = ST_CLEAR;
            else if (bus.req_valid) state_next_s = ST_LOOKUP;
            else                    state_next_s = ST_IDLE;
         end
         ST_LOOKUP: state_next_s = ST_RESP;
         ST_RESP: begin
            if (resp_valid_r && bus.resp_ready) state_next_s = ST_UPDATE;
            else                                state_next_s = ST_RESP;
         end
         ST_UPDATE: state_next_s = ST_IDLE;
         default:   state_next_s = ST_CLEAR;
      endcase
   end

   // Way selection from the stored tree of the latched set.
   always_comb begin
      rd_tree_s      = plru_mem[set_r];
      chosen_way_s   = way_r;
      chosen_evict_s = 1'b0;
      if (hit_r) begin
         chosen_way_s   = way_r;
         chosen_evict_s = 1'b0;
      end else if (inv_r != {N_WAY{1'b0}}) begin
         chosen_way_s   = lowest_set(inv_r);
         chosen_evict_s = 1'b0;
      end else begin
         chosen_way_s   = plru_victim(rd_tree_s);
         chosen_evict_s = 1'b1;
      end
   end

   // State, sweep counter, request latch and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_CLEAR;
         cnt_r        <= {SET_W{1'b0}};
         busy_r       <= 1'b1;
         req_ready_r  <= 1'b0;
         resp_valid_r <= 1'b0;
         resp_way_r   <= {WAY_W{1'b0}};
         resp_evict_r <= 1'b0;
      end else begin
         state_r      <= state_next_s;
         busy_r       <= (state_next_s == ST_CLEAR);
         req_ready_r  <= (state_next_s == ST_IDLE);
         resp_valid_r <= (state_next_s == ST_RESP);
         if (state_r == ST_CLEAR) begin
            cnt_r <= cnt_r + SET_W'(1);
         end else if (state_next_s == ST_CLEAR) begin
            cnt_r <= {SET_W{1'b0}};
         end
         if (state_r == ST_IDLE && !clear_req && bus.req_valid) begin
            set_r <= bus.req_set;
            hit_r <= bus.req_hit;
            way_r <= bus.req_way;
            inv_r <= bus.req_inv_mask;
         end
         if (state_r == ST_LOOKUP) begin
            tree_r       <= rd_tree_s;
            resp_way_r   <= chosen_way_s;
            resp_evict_r <= chosen_evict_s;
         end
      end
   end

   // PLRU storage: cleared one set per cycle by the sweep, MRU-updated after each handshake.
   always_ff @(posedge clk) begin
      if (!rst && state_r == ST_CLEAR) begin
         plru_mem[cnt_r] <= {NODES{1'b0}};
      end else if (!rst && state_r == ST_UPDATE) begin
         plru_mem[set_r] <= plru_touch(tree_r, resp_way_r);
      end
   end

endmodule
